// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI register bridge:
//   - state_e  : bridge FSM states (every frame starts in ST_CMD)
//   - command byte layout: bit 7 selects read/write, bits 6:4 must be zero,
//     bits 3:0 are the start address
//   - register map sizes: NUM_RW read/write registers followed by
//     NUM_REGS-NUM_RW read-only status registers
package spi_pkg;

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ILL_MSB  = 6;
    localparam int CMD_ILL_LSB  = 4;
    localparam int CMD_ADDR_MSB = 3;

    localparam int NUM_RW   = 12;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_RO   = NUM_REGS - NUM_RW;

    localparam logic [ADDR_W-1:0] LAST_RW = ADDR_W'(NUM_RW - 1);

    // A command is illegal when any of the reserved address bits are set.
    function automatic logic cmd_illegal(input logic [7:0] cmd);
        return cmd[CMD_ILL_MSB:CMD_ILL_LSB] != '0;
    endfunction

    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return cmd[CMD_RW_BIT];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:0];
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if
// Byte-stream handshake between an SPI slave shift register and the bridge.
//   rx_data/rx_valid : byte received from the slave, one-cycle valid pulse
//   cs_n             : synchronised slave select, active low
//   tx_data/tx_latch : next response byte and its one-cycle load strobe
//   wr_strobe/wr_addr: committed register write notification
// master = the side that drives the SPI byte stream, slave = the bridge.
interface spi_reg_bridge_if;
    import spi_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              cs_n;
    logic [7:0]        tx_data;
    logic              tx_latch;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output rx_data, rx_valid, cs_n,
        input  tx_data, tx_latch, wr_strobe, wr_addr
    );

    modport slave (
        input  rx_data, rx_valid, cs_n,
        output tx_data, tx_latch, wr_strobe, wr_addr
    );

endinterface

// File: rtl/spi_regfile.sv
// spi_regfile
// NUM_RW read/write byte registers plus a read-only view of status_in.
//   clk_system, reset : clock, synchronous active-high reset (clears RW regs)
//   rd_addr/rd_data   : combinational read port over all NUM_REGS addresses
//   wr_en/wr_addr/wr_data : write port; writes above LAST_RW are ignored
//   status_in         : read-only registers NUM_RW.., byte k at [8k+7:8k]
//   regs_out          : flattened RW registers, reg n at [8n+7:8n]
module spi_regfile
    import spi_pkg::*;
(
    input  logic                  clk_system,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [8*NUM_RO-1:0]   status_in,
    output logic [8*NUM_RW-1:0]   regs_out
);

    logic [7:0] regs_q [NUM_RW];
    logic [7:0] regs_d [NUM_RW];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr <= LAST_RW)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk_system) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The RO block starts at address 12 (4'b1100), so the low two address
    // bits directly select the status byte.
    always_comb begin
        if (rd_addr <= LAST_RW) begin
            rd_data = regs_q[rd_addr];
        end else begin
            rd_data = status_in[{rd_addr[1:0], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs_q[g];
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
// Turns the byte stream of an SPI slave into register reads and writes.
// The first byte of a frame is a command (bit 7 read, bits 3:0 address);
// following bytes either write successive registers or clock out successive
// register values. The pointer wraps 15 -> 0.
//   clk_system, reset : sole clock, synchronous active-high reset
//   rx_data/rx_valid  : received byte and its one-cycle valid pulse
//   cs_n              : synchronised slave select (high = frame end)
//   tx_data/tx_latch  : response byte and its one-cycle load strobe
//   regs_out          : RW registers 0..11
//   status_in         : RO registers 12..15
//   wr_strobe/wr_addr : one pulse per committed write
//   err_count         : saturating illegal-command counter
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter logic [7:0] RESP_IDLE = 8'hA5,
    parameter logic [7:0] RESP_ERR  = 8'hEE
) (
    input  logic                clk_system,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                cs_n,
    output logic [7:0]          tx_data,
    output logic                tx_latch,
    output logic [8*NUM_RW-1:0] regs_out,
    input  logic [8*NUM_RO-1:0] status_in,
    output logic                wr_strobe,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [7:0]          err_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_latch_q, tx_latch_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        err_q, err_d;
    logic              cs_prev_q, cs_prev_d;
    logic              idle_pend_q, idle_pend_d;

    logic [ADDR_W-1:0] rf_rd_addr;
    logic [7:0]        rf_rd_data;
    logic              rf_wr_en;
    logic              rx_latch;
    logic              frame_end;

    // A read command addresses the register file directly; inside a read
    // burst the pointer does.
    assign rf_rd_addr = (state_q == ST_CMD) ? cmd_addr(rx_data) : ptr_q;

    // cs_prev_q resets low so that a slave select already high when reset
    // releases still produces one idle-byte load.
    assign frame_end = cs_n && !cs_prev_q;

    spi_regfile u_regfile (
        .clk_system (clk_system),
        .reset      (reset),
        .rd_addr    (rf_rd_addr),
        .rd_data    (rf_rd_data),
        .wr_en      (rf_wr_en),
        .wr_addr    (ptr_q),
        .wr_data    (rx_data),
        .status_in  (status_in),
        .regs_out   (regs_out)
    );

    // Next-state and response logic. A byte arriving together with cs_n
    // high is still handled in the current state; the frame-end idle load
    // then yields to any byte-driven load and is deferred by one cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        tx_latch_d  = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;
        idle_pend_d = idle_pend_q;
        cs_prev_d   = cs_n;
        rf_wr_en    = 1'b0;
        rx_latch    = 1'b0;

        if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    if (cmd_illegal(rx_data)) begin
                        tx_data_d = RESP_ERR;
                        rx_latch  = 1'b1;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        state_d = ST_ERROR;
                    end else if (cmd_is_read(rx_data)) begin
                        tx_data_d = rf_rd_data;
                        rx_latch  = 1'b1;
                        ptr_d     = cmd_addr(rx_data) + 1'b1;
                        state_d   = ST_READ;
                    end else begin
                        ptr_d   = cmd_addr(rx_data);
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ptr_q <= LAST_RW) begin
                        rf_wr_en    = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                    end
                    ptr_d = ptr_q + 1'b1;
                end
                ST_READ: begin
                    tx_data_d = rf_rd_data;
                    rx_latch  = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                end
                default: begin
                end
            endcase
        end

        if (rx_latch) begin
            tx_latch_d = 1'b1;
            if (frame_end) begin
                idle_pend_d = 1'b1;
            end
        end else if (frame_end || idle_pend_q) begin
            tx_data_d   = RESP_IDLE;
            tx_latch_d  = 1'b1;
            idle_pend_d = 1'b0;
        end

        if (cs_n) begin
            state_d = ST_CMD;
        end
    end

    always_ff @(posedge clk_system) begin
        if (reset) begin
            state_q     <= ST_CMD;
            ptr_q       <= '0;
            tx_data_q   <= RESP_IDLE;
            tx_latch_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= '0;
            cs_prev_q   <= 1'b0;
            idle_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tx_data_q   <= tx_data_d;
            tx_latch_q  <= tx_latch_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            cs_prev_q   <= cs_prev_d;
            idle_pend_q <= idle_pend_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_latch  = tx_latch_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge
// Self-checking bench for spi_reg_bridge. A frame-level reference model
// (register array + error counter) predicts, per frame, the sequence of
// latched response bytes, the sequence of write addresses, the final
// register contents and the error count.
module tb_spi_reg_bridge;
    import spi_pkg::*;

    logic        clk_system = 1'b0;
    logic        reset;
    logic [31:0] status_in;
    logic [95:0] regs_out;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    spi_reg_bridge_if bus ();

    always #25 clk_system = ~clk_system;

    spi_reg_bridge #(
        .RESP_IDLE (8'hA5),
        .RESP_ERR  (8'hEE)
    ) dut (
        .clk_system (clk_system),
        .reset      (reset),
        .rx_data    (bus.rx_data),
        .rx_valid   (bus.rx_valid),
        .cs_n       (bus.cs_n),
        .tx_data    (bus.tx_data),
        .tx_latch   (bus.tx_latch),
        .regs_out   (regs_out),
        .status_in  (status_in),
        .wr_strobe  (bus.wr_strobe),
        .wr_addr    (bus.wr_addr),
        .err_count  (err_count)
    );

    // Observed events, sampled on the falling edge
    logic [7:0] obs_lat[$];
    logic [3:0] obs_wa[$];

    always @(negedge clk_system) begin
        if (bus.tx_latch === 1'b1) obs_lat.push_back(bus.tx_data);
        if (bus.wr_strobe === 1'b1) obs_wa.push_back(bus.wr_addr);
    end

    // Reference model state
    logic [7:0] model_regs [12];
    int         model_err;
    logic [7:0] frame_q[$];
    logic [7:0] exp_lat[$];
    logic [3:0] exp_wa[$];

    function automatic logic [7:0] model_value(input int a);
        if (a < 12) return model_regs[a];
        return status_in[(a - 12) * 8 +: 8];
    endfunction

    function automatic logic [95:0] model_flat();
        logic [95:0] r;
        for (int i = 0; i < 12; i++) r[8*i +: 8] = model_regs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) model_regs[i] = 8'h00;
        model_err = 0;
    endtask

    // Predict one whole frame from the command rules
    task automatic model_frame();
        logic [7:0] cmd;
        int         addr;
        int         a;
        exp_lat.delete();
        exp_wa.delete();
        if (frame_q.size() > 0) begin
            cmd  = frame_q[0];
            addr = int'(cmd[3:0]);
            if (cmd[6:4] != 3'b000) begin
                exp_lat.push_back(8'hEE);
                if (model_err < 255) model_err++;
            end else if (cmd[7]) begin
                for (int i = 0; i < frame_q.size(); i++)
                    exp_lat.push_back(model_value((addr + i) % 16));
            end else begin
                for (int i = 1; i < frame_q.size(); i++) begin
                    a = (addr + i - 1) % 16;
                    if (a < 12) begin
                        model_regs[a] = frame_q[i];
                        exp_wa.push_back(4'(a));
                    end
                end
            end
        end
        exp_lat.push_back(8'hA5);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_system);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk_system);
        bus.rx_valid = 1'b0;
    endtask

    // Drive frame_q as one frame; max_gap=0 gives back-to-back bytes,
    // collide raises cs_n together with the last byte.
    task automatic applyStimulus(input int max_gap, input bit collide);
        int gap;
        obs_lat.delete();
        obs_wa.delete();
        @(negedge clk_system);
        bus.cs_n = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk_system);
            bus.rx_data  = frame_q[i];
            bus.rx_valid = 1'b1;
            if (collide && (i == frame_q.size() - 1)) bus.cs_n = 1'b1;
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                @(negedge clk_system);
                bus.rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk_system);
            end
        end
        @(negedge clk_system);
        bus.rx_valid = 1'b0;
        bus.cs_n     = 1'b1;
        repeat (5) @(negedge clk_system);
    endtask

    task automatic random_frame();
        logic [7:0] cmd;
        int         len;
        frame_q.delete();
        cmd = 8'($urandom);
        if ($urandom_range(0, 7) != 0) cmd[6:4] = 3'b000;
        else if (cmd[6:4] == 3'b000) cmd[6:4] = 3'b101;
        frame_q.push_back(cmd);
        len = $urandom_range(0, 6);
        for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
        status_in = $urandom;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        status_in    = 32'h0;
        model_reset();
        repeat (3) @(negedge clk_system);
        n_checks++;
        if (regs_out !== 96'h0 || err_count !== 8'h00 || bus.wr_strobe !== 1'b0 ||
            bus.wr_addr !== 4'h0 || bus.tx_latch !== 1'b0 || bus.tx_data !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL reset_values: regs=%h err=%h ws=%b wa=%h tl=%b td=%h required 0/0/0/0/0/a5",
                     regs_out, err_count, bus.wr_strobe, bus.wr_addr, bus.tx_latch, bus.tx_data);
        end
        reset = 1'b0;
        obs_lat.delete();
        repeat (5) @(negedge clk_system);
        n_checks++;
        if (obs_lat.size() != 1 || obs_lat[0] !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL reset_idle_latch: got %0d latches (first %h) required 1 of a5",
                     obs_lat.size(), obs_lat.size() > 0 ? obs_lat[0] : 8'hxx);
        end
    endtask

    task automatic test_illegal();
        frame_q = '{8'h30, 8'h12, 8'h05, 8'h56};
        status_in = $urandom;
        applyStimulus(2, 1'b0);
        model_frame();
        n_checks++;
        if (obs_lat.size() != 2 || obs_lat[0] !== 8'hEE || obs_lat[1] !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL illegal_latches: got %0d latches required ee,a5", obs_lat.size());
        end
        n_checks++;
        if (err_count !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL illegal_err_count: got %0d required 1", err_count);
        end
        n_checks++;
        if (regs_out !== 96'h0 || obs_wa.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL illegal_ignored: regs=%h writes=%0d required all zero, 0 writes",
                     regs_out, obs_wa.size());
        end
    endtask

    task automatic test_write_burst();
        @(negedge clk_system);
        bus.cs_n = 1'b0;
        send_byte(8'h03);
        n_checks++;
        if (bus.wr_strobe !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wr_cmd_no_strobe: got %b required 0", bus.wr_strobe);
        end
        send_byte(8'h11);
        n_checks++;
        if (bus.wr_strobe !== 1'b1 || bus.wr_addr !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL wr_latency_3: strobe=%b addr=%0d required 1 at 3", bus.wr_strobe, bus.wr_addr);
        end
        @(negedge clk_system);
        n_checks++;
        if (bus.wr_strobe !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wr_strobe_width: got %b required 0", bus.wr_strobe);
        end
        send_byte(8'h22);
        n_checks++;
        if (bus.wr_strobe !== 1'b1 || bus.wr_addr !== 4'd4) begin
            n_fail++;
            $display("[TB] FAIL wr_latency_4: strobe=%b addr=%0d required 1 at 4", bus.wr_strobe, bus.wr_addr);
        end
        @(negedge clk_system);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk_system);
        frame_q = '{8'h03, 8'h11, 8'h22};
        model_frame();
        n_checks++;
        if (regs_out[31:24] !== 8'h11 || regs_out[39:32] !== 8'h22) begin
            n_fail++;
            $display("[TB] FAIL wr_burst_regs: reg3=%h reg4=%h required 11 22", regs_out[31:24], regs_out[39:32]);
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] want[$];
        frame_q = '{8'h05, 8'h5A};
        applyStimulus(1, 1'b0);
        model_frame();
        status_in = {24'($urandom), 8'hC3};
        obs_lat.delete();
        @(negedge clk_system);
        bus.cs_n = 1'b0;
        send_byte(8'h85);
        n_checks++;
        if (bus.tx_latch !== 1'b1 || bus.tx_data !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL rd_latency: latch=%b data=%h required 1 with 5a", bus.tx_latch, bus.tx_data);
        end
        for (int i = 0; i < 7; i++) send_byte(8'($urandom));
        @(negedge clk_system);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk_system);
        want.push_back(8'h5A);
        for (int a = 6; a < 12; a++) want.push_back(model_regs[a]);
        want.push_back(8'hC3);
        want.push_back(8'hA5);
        n_checks++;
        if (obs_lat.size() != want.size()) begin
            n_fail++;
            $display("[TB] FAIL rd_burst_count: got %0d required %0d", obs_lat.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                n_checks++;
                if (obs_lat[i] !== want[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rd_burst_byte%0d: got %h required %h", i, obs_lat[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        frame_q = '{8'h0F, 8'h77, 8'h66};
        applyStimulus(2, 1'b0);
        model_frame();
        n_checks++;
        if (regs_out[7:0] !== 8'h66 || obs_wa.size() != 1 || obs_wa[0] !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap: reg0=%h writes=%0d required 66 with one write at 0",
                     regs_out[7:0], obs_wa.size());
        end
        n_checks++;
        if (regs_out !== model_flat()) begin
            n_fail++;
            $display("[TB] FAIL wrap_regs: got %h required %h", regs_out, model_flat());
        end
    endtask

    task automatic test_random(input int n_frames, input int max_gap, input bit allow_collide);
        for (int f = 0; f < n_frames; f++) begin
            random_frame();
            applyStimulus(max_gap, allow_collide && ($urandom_range(0, 1) == 1));
            model_frame();
            n_checks++;
            if (obs_lat.size() != exp_lat.size()) begin
                n_fail++;
                $display("[TB] FAIL rand_lat_count f%0d: got %0d required %0d", f, obs_lat.size(), exp_lat.size());
            end else begin
                for (int i = 0; i < exp_lat.size(); i++) begin
                    n_checks++;
                    if (obs_lat[i] !== exp_lat[i]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_lat f%0d b%0d: got %h required %h", f, i, obs_lat[i], exp_lat[i]);
                    end
                end
            end
            n_checks++;
            if (obs_wa != exp_wa) begin
                n_fail++;
                $display("[TB] FAIL rand_wr_addr f%0d: got %0d writes required %0d", f, obs_wa.size(), exp_wa.size());
            end
            n_checks++;
            if (regs_out !== model_flat() || err_count !== 8'(model_err)) begin
                n_fail++;
                $display("[TB] FAIL rand_state f%0d: regs=%h err=%0d required %h %0d",
                         f, regs_out, err_count, model_flat(), model_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random(20, 0, 1'b1);
    endtask

    task automatic test_err_saturation();
        for (int f = 0; f < 300; f++) begin
            @(negedge clk_system);
            bus.cs_n = 1'b0;
            send_byte(8'h30 | 8'($urandom_range(0, 15)));
            @(negedge clk_system);
            bus.cs_n = 1'b1;
            repeat (2) @(negedge clk_system);
        end
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL err_saturate: got %0d required 255", err_count);
        end
        model_err = 255;
    endtask

    task automatic test_reset_midframe();
        @(negedge clk_system);
        bus.cs_n = 1'b0;
        send_byte(8'h02);
        repeat (2) @(negedge clk_system);
        reset        = 1'b1;
        bus.rx_data  = 8'h9C;
        bus.rx_valid = 1'b1;
        @(negedge clk_system);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        model_reset();
        n_checks++;
        if (regs_out !== 96'h0 || err_count !== 8'h00 || bus.wr_strobe !== 1'b0 ||
            bus.wr_addr !== 4'h0 || bus.tx_latch !== 1'b0 || bus.tx_data !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: regs=%h err=%h ws=%b wa=%h tl=%b td=%h required 0/0/0/0/0/a5",
                     regs_out, err_count, bus.wr_strobe, bus.wr_addr, bus.tx_latch, bus.tx_data);
        end
        obs_lat.delete();
        @(negedge clk_system);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk_system);
        n_checks++;
        if (obs_lat.size() != 1 || obs_lat[0] !== 8'hA5 || regs_out !== 96'h0) begin
            n_fail++;
            $display("[TB] FAIL midframe_recover: got %0d latches regs=%h required one a5, regs zero",
                     obs_lat.size(), regs_out);
        end
        test_random(5, 2, 1'b0);
    endtask

    initial begin
        $display("[TB] starting spi_reg_bridge bench");
        test_reset();
        test_illegal();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_random(40, 3, 1'b0);
        test_back_to_back();
        test_err_saturation();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter RESP_IDLE, default 8'hA5: byte loaded into the SPI slave shift register when idle or at frame end.
REQ-002 SHALL have parameter RESP_ERR, default 8'hEE: byte loaded after an illegal command.
REQ-003 SHALL have port clk_system  input  1  system clock (20 MHz); sole clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the SPI slave (its rd_data).
REQ-006 SHALL have port rx_valid  input  1  one-cycle pulse marking rx_data valid (the slave's new_data); synchronous to clk_system.
REQ-007 SHALL have port cs_n  input  1  slave select, active-low, already synchronised to clk_system.
REQ-008 SHALL have port tx_data  output  8  next response byte (drives the slave's wr_data).
REQ-009 SHALL have port tx_latch  output  1  one-cycle load strobe (drives the slave's latch).
REQ-010 SHALL have port regs_out  output  96  RW registers 0..11, reg n at bits [8n+7:8n].
REQ-011 SHALL have port status_in  input  32  RO registers 12..15, reg 12+k at bits [8k+7:8k].
REQ-012 SHALL have port wr_strobe  output  1  one-cycle pulse on each committed register write.
REQ-013 SHALL have port wr_addr  output  4  address of the write flagged by wr_strobe.
REQ-014 SHALL have port err_count  output  8  saturating count of illegal commands.

Function
REQ-015 Command byte SHALL be: bit7 = 1 read / 0 write, bits6:0 = start address; bits6:4 nonzero = illegal.
REQ-016 FSM states SHALL be CMD, WRITE, READ, ERROR; every frame SHALL begin in CMD.
REQ-017 CMD + rx_valid, legal write: SHALL store addr[3:0] as the pointer and go to WRITE.
REQ-018 CMD + rx_valid, legal read: SHALL set tx_data to reg[addr] and pulse tx_latch on the next cycle, set pointer to addr+1, and go to READ.
REQ-019 WRITE + rx_valid: SHALL write rx_data to reg[pointer] if pointer <= 11, pulse wr_strobe with wr_addr = pointer on the next cycle, and increment the pointer.
REQ-020 Writes to pointers 12..15 SHALL be dropped: no register change, no wr_strobe, no error count; the pointer still increments.
REQ-021 READ + rx_valid: SHALL latch reg[pointer] (RO values sampled from status_in that cycle) on the next cycle and increment the pointer.
REQ-022 Pointer SHALL wrap from 15 to 0 in both bursts.
REQ-023 Illegal command: SHALL latch RESP_ERR on the next cycle, increment err_count (saturate at 255), and go to ERROR.
REQ-024 ERROR SHALL ignore all bytes until frame end.
REQ-025 Frame end (cs_n high): SHALL force the state to CMD.
REQ-026 On the first cycle of each frame end, SHALL latch RESP_IDLE with one tx_latch pulse; RESP_IDLE SHALL NOT re-latch while cs_n stays high.
REQ-027 rx_valid with cs_n high SHALL be processed in the current state before returning to CMD.
REQ-028 If an rx_valid-driven latch and the frame-end latch fall in the same cycle, the rx_valid latch SHALL win and RESP_IDLE SHALL follow on the next cycle.
REQ-029 tx_latch SHALL be at most one cycle wide, with tx_data stable during it.
REQ-030 Latency from rx_valid to tx_latch/wr_strobe SHALL be exactly 1 cycle.

Reset
REQ-031 Reset SHALL clear regs_out, err_count, pointer, wr_strobe, wr_addr and tx_latch to 0, set tx_data = RESP_IDLE, and enter state CMD.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no write commits in the reset cycle.
REQ-033 After reset release, SHALL issue one tx_latch of RESP_IDLE if cs_n is high.

Structure
REQ-034 FSM state encoding, command bit positions, NUM_RW = 12 and register count 16 SHALL live in shared package spi_pkg.
REQ-035 The register file (12 RW + RO mux, one read port, one write port) SHALL be sub-module spi_regfile; the FSM and response logic stay in spi_reg_bridge.

Verification
REQ-036 Write burst 8'h03, 8'h11, 8'h22 SHALL give reg3 = 11 and reg4 = 22, with wr_strobe at wr_addr 3 then 4.
REQ-037 Read with reg5 = 8'h5A, status_in[7:0] = 8'hC3: cmd 8'h85 then 7 dummy bytes SHALL latch 5A, then reg6..11, then C3 (reg12).
REQ-038 Wrap: write cmd 8'h0F, data 8'h77, 8'h66 SHALL drop the write to reg15 and set reg0 = 66.
REQ-039 Illegal cmd 8'h30 SHALL latch EE, raise err_count to 1, ignore following bytes, and latch A5 once cs_n rises; 300 illegal frames SHALL leave err_count at 255.
REQ-040 Reset asserted between a write command and its data byte SHALL leave the register unchanged and all outputs at reset values.
